// File: rtl/quine_vga_text_pkg.sv
// Shared definitions for quine_vga_text: default 640x480@60 timing, a clog2 helper
// and the default-width rgb_t type.
package quine_vga_pkg;

    localparam int DEF_H_VIS      = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;
    localparam int DEF_V_VIS      = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;
    localparam int DEF_COLOR_BITS = 2;

    typedef logic [3*DEF_COLOR_BITS-1:0] rgb_t;

    // Smallest r with 2**r >= v; usable in constant expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/quine_vga_text_if.sv
// Text+font ROM bus of quine_vga_text: the generator drives the address, the ROM
// returns the glyph row a fixed number of cycles later.
interface quine_vga_text_if #(
    parameter int RA     = 16,
    parameter int CHAR_W = 8
);
    logic [RA-1:0]     rom_addr;
    logic [CHAR_W-1:0] glyph_row;

    modport master (output rom_addr, input glyph_row);
    modport slave  (input rom_addr, output glyph_row);
endinterface

// File: rtl/quine_vga_text_timing.sv
// Raster counters for quine_vga_text: hcnt/vcnt, raw sync-active and visible
// flags, and the frame-start strobe.
module quine_vga_timing
    import quine_vga_pkg::*;
#(
    parameter int H_VIS  = DEF_H_VIS,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_VIS  = DEF_V_VIS,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    localparam int HT    = H_VIS + H_FP + H_SYNC + H_BP,
    localparam int VT    = V_VIS + V_FP + V_SYNC + V_BP,
    localparam int HW    = clog2(HT),
    localparam int VW    = clog2(VT)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          h_act,
    output logic          v_act,
    output logic          vis,
    output logic          frame_start
);

    localparam int HS_BEG = H_VIS + H_FP;
    localparam int HS_END = HS_BEG + H_SYNC;
    localparam int VS_BEG = V_VIS + V_FP;
    localparam int VS_END = VS_BEG + V_SYNC;

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == HW'(HT - 1)) begin
            hcnt <= '0;
            vcnt <= (vcnt == VW'(VT - 1)) ? '0 : vcnt + VW'(1);
        end else begin
            hcnt <= hcnt + HW'(1);
        end
    end

    // Raw flags are "sync active", independent of the output polarity.
    assign h_act       = (hcnt >= HW'(HS_BEG)) && (hcnt < HW'(HS_END));
    assign v_act       = (vcnt >= VW'(VS_BEG)) && (vcnt < VW'(VS_END));
    assign vis         = (hcnt < HW'(H_VIS)) && (vcnt < VW'(V_VIS));
    assign frame_start = (hcnt == '0) && (vcnt == '0);

endmodule

// File: rtl/quine_vga_text.sv
// Character-cell VGA text generator: raster timing, per-frame scroll, glyph ROM
// addressing, latency-matched delay line and colour mux. Optional blinking cursor
// is built when QUINE_VGA_CURSOR_EN is defined.
module quine_vga_text
    import quine_vga_pkg::*;
#(
    parameter int H_VIS      = DEF_H_VIS,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_VIS      = DEF_V_VIS,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit SYNC_POL   = 1'b0,
    parameter int COLOR_BITS = DEF_COLOR_BITS,
    parameter int CHAR_W     = 8,
    parameter int CHAR_H     = 16,
    parameter int TEXT_ROWS  = 64,
    parameter int ROM_LAT    = 1,
    localparam int CCW       = clog2(H_VIS / CHAR_W),
    localparam int CW        = 3 * COLOR_BITS
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              scroll_en,
    input  logic [CW-1:0]                     fg_color,
    input  logic [CW-1:0]                     bg_color,
`ifdef QUINE_VGA_CURSOR_EN
    input  logic [CCW-1:0]                    cursor_col,
    input  logic [clog2(V_VIS / CHAR_H)-1:0]  cursor_row,
`endif
    quine_vga_text_if.master                  rom,
    output logic                              hsync,
    output logic                              vsync,
    output logic                              de,
    output logic [CW-1:0]                     rgb,
    output logic                              frame_tick
);

    localparam int HT  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int VT  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW  = clog2(HT);
    localparam int VW  = clog2(VT);
    localparam int TRW = clog2(TEXT_ROWS);
    localparam int GLW = clog2(CHAR_H);
    localparam int PXW = clog2(CHAR_W);
    localparam int SW  = TRW + GLW;

    typedef struct packed {
        logic           vld;
        logic           hs;
        logic           vs;
        logic           tick;
        logic           swap;
        logic [PXW-1:0] px;
    } stage_t;

    function automatic logic [CW-1:0] pixel_color(
        input logic          on_vis,
        input logic          ink,
        input logic [CW-1:0] fg,
        input logic [CW-1:0] bg
    );
        if (!on_vis) begin
            return '0;
        end
        return ink ? fg : bg;
    endfunction

    logic [HW-1:0]  hcnt;
    logic [VW-1:0]  vcnt;
    logic           h_act;
    logic           v_act;
    logic           vis;
    logic           frame_start;

    logic [SW-1:0]  scroll_line;
    logic [SW-1:0]  scroll_cur;
    logic [SW-1:0]  eff_line;
    logic [TRW-1:0] text_row;
    logic [CCW-1:0] text_col;
    logic [GLW-1:0] glyph_line;
    logic           swap_p0;
    stage_t         stg_p0;
    stage_t         stg_p [1:ROM_LAT];
    stage_t         stg_last;
    logic           ink;

    quine_vga_timing #(
        .H_VIS  (H_VIS),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_VIS  (V_VIS),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .h_act       (h_act),
        .v_act       (v_act),
        .vis         (vis),
        .frame_start (frame_start)
    );

    // Stage p0: counter state. A step requested at frame start already applies
    // to that frame's line 0, so the address uses the incremented value directly.
    assign scroll_cur = (frame_start && scroll_en) ? scroll_line + SW'(1) : scroll_line;

    always_ff @(posedge clk) begin
        if (rst) begin
            scroll_line <= '0;
        end else if (frame_start) begin
            scroll_line <= scroll_cur;
        end
    end

    assign eff_line   = SW'(vcnt) + scroll_cur;
    assign text_row   = eff_line[SW-1:GLW];
    assign glyph_line = eff_line[GLW-1:0];
    assign text_col   = CCW'(hcnt >> PXW);

    assign rom.rom_addr = {text_row, text_col, glyph_line};

`ifdef QUINE_VGA_CURSOR_EN
    logic [4:0] blink;
    logic       frame_last;

    // Advancing on the last pixel makes frame N (counted from reset) see blink=N.
    assign frame_last = (hcnt == HW'(HT - 1)) && (vcnt == VW'(VT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            blink <= '0;
        end else if (frame_last) begin
            blink <= blink + 5'd1;
        end
    end

    // Cursor is in screen cells, so it uses vcnt rather than the scrolled line.
    assign swap_p0 = vis && blink[4]
                     && (text_col == cursor_col)
                     && ((vcnt >> GLW) == VW'(cursor_row));
`else
    assign swap_p0 = 1'b0;
`endif

    assign stg_p0.vld  = vis;
    assign stg_p0.hs   = h_act;
    assign stg_p0.vs   = v_act;
    assign stg_p0.tick = frame_start;
    assign stg_p0.swap = swap_p0;
    assign stg_p0.px   = hcnt[PXW-1:0];

    // Stages p1..pROM_LAT: flags ride alongside the outstanding ROM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= ROM_LAT; i++) begin
                stg_p[i] <= '0;
            end
        end else begin
            stg_p[1] <= stg_p0;
            for (int i = 2; i <= ROM_LAT; i++) begin
                stg_p[i] <= stg_p[i-1];
            end
        end
    end

    assign stg_last = stg_p[ROM_LAT];
    // CHAR_W is a power of two, so CHAR_W-1-px is simply ~px.
    assign ink = rom.glyph_row[~stg_last.px] ^ stg_last.swap;

    // Output stage: glyph data and colour inputs are sampled here.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync      <= ~SYNC_POL;
            vsync      <= ~SYNC_POL;
            de         <= 1'b0;
            rgb        <= '0;
            frame_tick <= 1'b0;
        end else begin
            hsync      <= stg_last.hs ? SYNC_POL : ~SYNC_POL;
            vsync      <= stg_last.vs ? SYNC_POL : ~SYNC_POL;
            de         <= stg_last.vld;
            rgb        <= pixel_color(stg_last.vld, ink, fg_color, bg_color);
            frame_tick <= stg_last.tick;
        end
    end

endmodule

// File: tb/tb_quine_vga_text.sv
// Scoreboard bench for quine_vga_text on a reduced raster with a random glyph ROM,
// random colours/scroll and a mid-frame reset; cursor checks when QUINE_VGA_CURSOR_EN.
module tb_quine_vga_text;
    import quine_vga_pkg::*;

    localparam int H_VIS = 32, H_FP = 2, H_SYNC = 4, H_BP = 2;
    localparam int V_VIS = 16, V_FP = 1, V_SYNC = 2, V_BP = 1;
    localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FT = HT * VT;
    localparam int CHAR_W = 8, CHAR_H = 4, TEXT_ROWS = 4, ROM_LAT = 2;
    localparam int COLS = H_VIS / CHAR_W;
    localparam int LINES = TEXT_ROWS * CHAR_H;
    localparam int RA = 6;
    localparam bit SYNC_POL = 1'b0;

    typedef struct packed {
        logic          chk_addr;
        logic [RA-1:0] addr;
        logic          hs;
        logic          vs;
        logic          de;
        logic          tick;
        rgb_t          rgb;
    } exp_t;

    typedef struct packed {
        logic [RA-1:0] addr;
        logic          vis;
        logic          hs;
        logic          vs;
        logic          tick;
        logic          swap;
        logic [2:0]    px;
    } pos_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scroll_en = 1'b1;
    rgb_t fg = 6'h3F;
    rgb_t bg = 6'h05;
    logic hsync, vsync, de, frame_tick;
    rgb_t rgb;
`ifdef QUINE_VGA_CURSOR_EN
    logic [1:0] cursor_col = 2'd2;
    logic [1:0] cursor_row = 2'd1;
`endif

    quine_vga_text_if #(.RA(RA), .CHAR_W(CHAR_W)) rom_if();

    quine_vga_text #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(SYNC_POL), .COLOR_BITS(2), .CHAR_W(CHAR_W), .CHAR_H(CHAR_H),
        .TEXT_ROWS(TEXT_ROWS), .ROM_LAT(ROM_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scroll_en  (scroll_en),
        .fg_color   (fg),
        .bg_color   (bg),
`ifdef QUINE_VGA_CURSOR_EN
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
`endif
        .rom        (rom_if.master),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .rgb        (rgb),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // ROM model: address captured each edge, data valid ROM_LAT cycles later.
    logic [CHAR_W-1:0] rom_mem [64];
    logic [RA-1:0]     a_pipe [1:ROM_LAT];
    always @(posedge clk) begin
        a_pipe[1] <= rom_if.rom_addr;
        for (int i = 2; i <= ROM_LAT; i++) a_pipe[i] <= a_pipe[i-1];
    end
    assign rom_if.glyph_row = rom_mem[a_pipe[ROM_LAT]];

    exp_t exp_q[$];
    pos_t hist[$];
    int   m;
    int   scroll;
    int   n_tests = 0;
    int   n_fail = 0;

    function automatic pos_t describe(input int mm, input int sc);
        pos_t d;
        int p, x, y, eff, frame;
        p = mm % FT;
        x = p % HT;
        y = p / HT;
        frame = mm / FT;
        eff = (y + sc) % LINES;
        d.addr = RA'(((eff / CHAR_H) * COLS + (x / CHAR_W) % COLS) * CHAR_H + eff % CHAR_H);
        d.vis  = (x < H_VIS) && (y < V_VIS);
        d.hs   = (x >= H_VIS + H_FP) && (x < H_VIS + H_FP + H_SYNC);
        d.vs   = (y >= V_VIS + V_FP) && (y < V_VIS + V_FP + V_SYNC);
        d.tick = (p == 0);
        d.px   = 3'(x % CHAR_W);
`ifdef QUINE_VGA_CURSOR_EN
        d.swap = d.vis && (x / CHAR_W == 2) && (y / CHAR_H == 1) && ((frame % 32) >= 16);
`else
        d.swap = 1'b0;
`endif
        return d;
    endfunction

    // One clock of stimulus; pushes the response expected right after the next edge.
    task automatic cycle(input logic r);
        exp_t e;
        pos_t d, o;
        logic [CHAR_W-1:0] g;
        logic ink;
        @(negedge clk);
        rst = r;
        if ($urandom_range(0, 31) == 0) fg = rgb_t'($urandom);
        if ($urandom_range(0, 31) == 0) bg = rgb_t'($urandom);
        e = '0;
        e.hs = !SYNC_POL;
        e.vs = !SYNC_POL;
        if (r) begin
            m = 0;
            scroll = 0;
            hist.delete();
            exp_q.push_back(e);
            return;
        end
        if (m % FT == (VT - 1) * HT)
            scroll_en = (m / FT + 1 < 17) ? 1'b1 : 1'($urandom_range(0, 1));
        if (m % FT == 0 && scroll_en) scroll = (scroll + 1) % LINES;
        d = describe(m, scroll);
        hist.push_back(d);
        e.chk_addr = 1'b1;
        e.addr = d.addr;
        if (hist.size() > ROM_LAT) begin
            o = hist.pop_front();
            g = rom_mem[o.addr];
            ink = g[CHAR_W - 1 - int'(o.px)] ^ o.swap;
            e.hs   = o.hs ? SYNC_POL : !SYNC_POL;
            e.vs   = o.vs ? SYNC_POL : !SYNC_POL;
            e.de   = o.vis;
            e.tick = o.tick;
            e.rgb  = o.vis ? (ink ? fg : bg) : rgb_t'(0);
        end
        exp_q.push_back(e);
        m++;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    // Monitor: address sampled mid-cycle, registered outputs just after the edge.
    initial begin
        exp_t e;
        logic [RA-1:0] a_s;
        forever begin
            @(negedge clk);
            a_s = rom_if.rom_addr;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk_addr) check("rom_addr", 32'(a_s), 32'(e.addr));
                check("sync_de_tick", 32'({hsync, vsync, de, frame_tick}),
                      32'({e.hs, e.vs, e.de, e.tick}));
                check("rgb", 32'(rgb), 32'(e.rgb));
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) rom_mem[i] = CHAR_W'($urandom);
        rom_mem[0] = 8'b1000_0001;
        repeat (3) cycle(1'b1);
        for (int i = 0; i < 34 * FT && n_fail < 50; i++) cycle(1'b0);
        // Mid-frame reset at (x=20, y=10), held for three cycles.
        while (n_fail < 50 && (m % FT) != 10 * HT + 20) cycle(1'b0);
        repeat (3) cycle(1'b1);
        for (int i = 0; i < 2 * FT && n_fail < 50; i++) cycle(1'b0);
        repeat (3) @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
